// File: rtl/core_pkg.sv
// Shared fetch-stage constants and types: bus widths, memory depth, halt encoding,
// fetch FSM states and the IF/ID pipeline-register layout.
package core_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_DEPTH = 1024;
  localparam logic [DATA_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } ifid_t;

endpackage

// File: rtl/if_fetch_stage_pc_next_sel.sv
// Next-PC priority mux (redirect > flush > stall > sequential) with the
// redirect range check and the normal-capture qualifier.
module pc_next_sel
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W    = core_pkg::ADDR_W,
  parameter int unsigned MEM_DEPTH = core_pkg::MEM_DEPTH
) (
  input  fetch_state_t      i_state,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_range_err,
  output logic              o_capture
);

  localparam logic [ADDR_W-1:0] LP_LAST_PC = ADDR_W'(MEM_DEPTH - 1);

  logic w_redirect_live;

  always_comb begin
    w_redirect_live = i_redirect && (i_state != BOOT);
    o_range_err     = w_redirect_live && (i_redirect_pc > LP_LAST_PC);
    o_capture       = (i_state == RUN) && !i_redirect && !i_flush && !i_stall;

    o_pc_next = i_pc;
    if (w_redirect_live) begin
      // Out-of-range targets leave the PC where it is.
      if (!o_range_err) begin
        o_pc_next = i_redirect_pc;
      end
    end else if (o_capture) begin
      o_pc_next = (i_pc == LP_LAST_PC) ? '0 : i_pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID capture, BOOT/RUN/HALTED control.
// Define IF_FETCH_PERF_EN to add the saturating fetch_count_o capture counter.
module if_fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned       ADDR_W     = core_pkg::ADDR_W,
  parameter int unsigned       DATA_W     = core_pkg::DATA_W,
  parameter int unsigned       MEM_DEPTH  = core_pkg::MEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] HALT_INSTR = core_pkg::HALT_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_instr_i,
  output logic              ifid_valid_o,
  output logic [DATA_W-1:0] ifid_instr_o,
  output logic [ADDR_W-1:0] ifid_pc_o,
  output logic              halted_o,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0]       fetch_count_o,
`endif
  output logic              err_o
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  ifid_t             r_ifid;
  logic              r_err;
  logic              w_range_err;
  logic              w_capture;
  logic              w_halt_hit;
  logic              w_halted;

  pc_next_sel #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_pc_next_sel (
    .i_state       (r_state),
    .i_redirect    (redirect_i),
    .i_redirect_pc (redirect_pc_i),
    .i_flush       (flush_i),
    .i_stall       (stall_i),
    .i_pc          (r_pc),
    .o_pc_next     (w_pc_next),
    .o_range_err   (w_range_err),
    .o_capture     (w_capture)
  );

  assign w_halt_hit = w_capture && (imem_instr_i == HALT_INSTR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        if (w_range_err || w_halt_hit) begin
          w_state_next = HALTED;
        end
      end
      HALTED: begin
        if (redirect_i && !w_range_err) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  always_comb begin
    w_halted = (r_state == HALTED);
  end

  // IF/ID: capture on a normal RUN cycle, hold on a bare stall (and in BOOT),
  // otherwise drop the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_ifid <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_range_err) begin
        r_err <= 1'b1;
      end
      if (w_capture) begin
        r_ifid.valid <= 1'b1;
        r_ifid.instr <= imem_instr_i;
        r_ifid.pc    <= r_pc;
      end else if (r_state != BOOT) begin
        if (redirect_i || flush_i || !stall_i) begin
          r_ifid.valid <= 1'b0;
        end
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_capture && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count_o = r_fetch_count;
`endif

  assign imem_addr_o  = r_pc;
  assign ifid_valid_o = r_ifid.valid;
  assign ifid_instr_o = r_ifid.instr;
  assign ifid_pc_o    = r_ifid.pc;
  assign halted_o     = w_halted;
  assign err_o        = r_err;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a 1024-word
// combinational instruction memory holding word k = k+100.
module tb_if_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic        halted_o;
  logic        err_o;

  logic [31:0] mem [0:1023];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc_o     (ifid_pc_o),
    .halted_o      (halted_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  always_comb imem_instr_i = mem[imem_addr_o[9:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ifid(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] addr);
    check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
    if (v) begin
      check({tag, ".pc"}, ifid_pc_o, pc);
      check({tag, ".instr"}, ifid_instr_o, instr);
    end
    check({tag, ".addr"}, imem_addr_o, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'(k + 100);
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    tick(); tick();
    expect_ifid("reset", 1'b0, 0, 0, 0);
    check("reset.pc", ifid_pc_o, 0);
    check("reset.instr", ifid_instr_o, 0);
    check("reset.halted", {31'd0, halted_o}, 0);
    check("reset.err", {31'd0, err_o}, 0);

    // Boot cycle, then one instruction per cycle.
    rst = 1'b0;
    tick();
    expect_ifid("boot", 1'b0, 0, 0, 0);
    for (int k = 0; k <= 5; k++) begin
      tick();
      expect_ifid("seq", 1'b1, 32'(k), 32'(k + 100), 32'(k + 1));
    end

    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_ifid("stall", 1'b1, 5, 105, 6);
    end
    stall_i = 1'b0;
    tick();
    expect_ifid("resume", 1'b1, 6, 106, 7);
    tick();
    expect_ifid("pre_redir", 1'b1, 7, 107, 8);

    // Redirect wins over a simultaneous stall.
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 40;
    tick();
    expect_ifid("redir", 1'b0, 0, 0, 40);
    stall_i = 1'b0; redirect_i = 1'b0;
    tick();
    expect_ifid("redir_tgt", 1'b1, 40, 140, 41);

    flush_i = 1'b1;
    tick();
    expect_ifid("flush", 1'b0, 0, 0, 41);
    flush_i = 1'b0;
    tick();
    expect_ifid("refetch", 1'b1, 41, 141, 42);

    redirect_i = 1'b1; redirect_pc_i = 1023;
    tick();
    expect_ifid("to_last", 1'b0, 0, 0, 1023);
    redirect_i = 1'b0;
    tick();
    expect_ifid("wrap", 1'b1, 1023, 1123, 0);
    tick();
    expect_ifid("wrap0", 1'b1, 0, 100, 1);

    redirect_i = 1'b1; redirect_pc_i = 2000;
    tick();
    check("range.err", {31'd0, err_o}, 1);
    check("range.halted", {31'd0, halted_o}, 1);
    check("range.addr", imem_addr_o, 1);
    redirect_i = 1'b0;
    tick();
    check("range.sticky", {31'd0, err_o}, 1);
    check("range.addr2", imem_addr_o, 1);
    check("range.valid", {31'd0, ifid_valid_o}, 0);
    rst = 1'b1;
    tick();
    check("rst.err", {31'd0, err_o}, 0);
    check("rst.halted", {31'd0, halted_o}, 0);
    check("rst.addr", imem_addr_o, 0);

    // Halt encoding at word 3.
    mem[3] = HALT;
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) tick();
    check("pre_halt.halted", {31'd0, halted_o}, 0);
    tick();
    expect_ifid("halt_cap", 1'b1, 3, HALT, 4);
    check("halt.halted", {31'd0, halted_o}, 1);
    tick();
    expect_ifid("halted1", 1'b0, 0, 0, 4);
    tick();
    expect_ifid("halted2", 1'b0, 0, 0, 4);
    check("halted2.halted", {31'd0, halted_o}, 1);
    redirect_i = 1'b1; redirect_pc_i = 0;
    tick();
    check("unhalt.halted", {31'd0, halted_o}, 0);
    expect_ifid("unhalt", 1'b0, 0, 0, 0);
    redirect_i = 1'b0;
    tick();
    expect_ifid("unhalt_run", 1'b1, 0, 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC register and drives the memory word address.
- Captures the returned instruction into the IF/ID pipeline register with a valid bit.
- Handles stall, flush, branch redirect and halt for the pipelined core.

Parameters:
- ADDR_W, 32, width of PC and memory address bus
- DATA_W, 32, instruction width
- MEM_DEPTH, 1024, instruction memory depth in words
- RESET_PC, 0, PC value loaded on reset (word address)
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  hold PC and IF/ID contents
- flush_i  in  1  squash IF/ID entry
- redirect_i  in  1  load PC from redirect_pc_i (taken branch/jump)
- redirect_pc_i  in  ADDR_W  redirect target, word address
- imem_addr_o  out  ADDR_W  address to instruction memory, equals pc_q
- imem_instr_i  in  DATA_W  instruction returned by memory, combinational within the cycle
- ifid_valid_o  out  1  IF/ID entry valid
- ifid_instr_o  out  DATA_W  IF/ID instruction
- ifid_pc_o  out  ADDR_W  PC of the IF/ID instruction
- halted_o  out  1  FSM in HALTED
- err_o  out  1  sticky: redirect target out of range

Behaviour:
- Addressing: PC is a word address. Sequential fetch increments by 1, not 4. imem_addr_o = pc_q, registered with no combinational path from inputs.
- Reset: pc_q=RESET_PC, ifid_valid_o=0, ifid_instr_o=0, ifid_pc_o=0, err_o=0, state=BOOT, halted_o=0. A reset asserted mid-operation discards everything on the same edge.
- BOOT: one cycle so the memory output settles. ifid_valid_o stays 0, PC holds. Moves to RUN unconditionally.
- RUN: per cycle, priority redirect > flush > stall > normal.
  - redirect: pc_q<=redirect_pc_i; ifid_valid_o<=0 (wrong-path instruction dropped). Applies even with stall_i=1.
  - flush without redirect: ifid_valid_o<=0; PC holds, so the same address is refetched.
  - stall: pc_q and all ifid_* hold.
  - normal: ifid_instr_o<=imem_instr_i; ifid_pc_o<=pc_q; ifid_valid_o<=1; pc_q<=(pc_q+1) mod MEM_DEPTH, so MEM_DEPTH-1 wraps to 0.
- Halt: on a normal capture with imem_instr_i==HALT_INSTR, the instruction is captured valid and the FSM goes to HALTED.
- HALTED: pc_q frozen.
  - Next cycle ifid_valid_o<=0 unless stall_i (hold).
  - redirect_i returns to RUN with the new PC. This recovers from a wrong-path halt.
  - flush clears valid.
- Range check: redirect with redirect_pc_i >= MEM_DEPTH sets err_o (cleared only by rst), goes to HALTED, and leaves pc_q unchanged.
- Latency: the instruction at address A is visible on ifid_* one edge after pc_q==A (no stall).
- Throughput: 1 instruction/cycle in RUN.
- Reset-out: first valid IF/ID is RESET_PC on the 2nd edge after rst deasserts.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- Defined: adds output fetch_count_o (32 bits). Resets to 0 and increments on every normal capture. Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; no other behavioural difference.

Decomposition:
- Shared package core_pkg:
  - ADDR_W, DATA_W, MEM_DEPTH, HALT_INSTR constants
  - fetch_state_t enum {BOOT, RUN, HALTED}
  - ifid_t struct {valid, instr, pc}
- One natural sub-module, pc_next_sel: pure combinational priority mux computing next pc_q and the range-check flag. FSM and IF/ID register stay in the top.

Test Plan:
- Reset, memory word k = k+100, no stall. Response: ifid_valid rises on 2nd edge after rst low; ifid_pc/instr = 0/100, 1/101, 2/102 on consecutive cycles.
- stall_i high 3 cycles while ifid_pc=5. Response: ifid_pc=5 and instr held 3 cycles, imem_addr_o=6 held; resumes with pc 6.
- redirect_i with redirect_pc_i=40 while pc_q=8, stall_i=1. Response: next cycle ifid_valid=0, imem_addr_o=40; following cycle ifid_pc=40.
- HALT_INSTR at word 3. Response: ifid_pc=3 valid, halted_o=1, then ifid_valid=0 and imem_addr_o frozen at 4; redirect to 0 resumes fetch.
- PC at 1023, no redirect. Response: next imem_addr_o=0.
- redirect_pc_i=2000. Response: err_o=1 sticky, halted_o=1, pc unchanged; rst clears both.
